// File: rtl/cp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cp_pkg
//  Brief    : Shared types and constants for the control-plane table bus:
//             FSM state encoding, bus field widths, table IDs and the
//             masked-merge helper used by read-modify-write.
//  Revision : 1.0 - initial release
// ============================================================================
package cp_pkg;

  // Initiator transaction state; explicit 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } cp_state_e;

  localparam int CP_COL_W  = 15;
  localparam int CP_ROW_W  = 15;
  localparam int CP_DATA_W = 64;
  localparam int CP_WAIT_W = 4;

  // Table IDs as wired at the SoC level.
  localparam int TAB_CORE  = 0;
  localparam int TAB_CACHE = 1;
  localparam int TAB_TLB   = 2;
  localparam int TAB_PRED  = 3;

  // Keep old bits where mask is 0, take new bits where mask is 1.
  function automatic logic [CP_DATA_W-1:0] cp_merge(
    input logic [CP_DATA_W-1:0] old_val,
    input logic [CP_DATA_W-1:0] new_val,
    input logic [CP_DATA_W-1:0] mask
  );
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage : cp_pkg
`default_nettype wire

// File: rtl/cp_table_rdata_mux.sv
`default_nettype none
// ============================================================================
//  Module   : cp_table_rdata_mux
//  Brief    : Selects one table's 64-bit rdata slice from the concatenated
//             table read bus by table ID. Out-of-range IDs return zero.
//  Revision : 1.0 - initial release
// ============================================================================
module cp_table_rdata_mux
  import cp_pkg::*;
#(
  parameter int NUM_TABLES = 4,
  parameter int TABLE_ID_W = 2
) (
  input  logic [TABLE_ID_W-1:0]           table_id,
  input  logic [CP_DATA_W*NUM_TABLES-1:0] tab_rdata,
  output logic [CP_DATA_W-1:0]            rdata
);

  // Pick the slice whose index matches the latched table ID.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_TABLES; i++) begin
      if (32'(table_id) == 32'(i)) begin
        rdata = tab_rdata[CP_DATA_W*i +: CP_DATA_W];
      end
    end
  end

endmodule : cp_table_rdata_mux
`default_nettype wire

// File: rtl/cp_table_access_master.sv
`default_nettype none
// ============================================================================
//  Module   : cp_table_access_master
//  Brief    : Control-plane table bus initiator. Takes one read/write request
//             at a time, drives col/row/wdata/wen to the selected table,
//             samples its combinational rdata and returns a response.
//             Optional macro CP_ACCESS_MASK_EN adds req_wmask and turns
//             writes into read-modify-write returning the old value.
//  Revision : 1.0 - initial release
// ============================================================================
module cp_table_access_master
  import cp_pkg::*;
#(
  parameter int NUM_TABLES = 4,
  parameter int TABLE_ID_W = 2,
  parameter int RD_WAIT    = 1
) (
  input  logic                            SYS_CLK,
  input  logic                            DETECT_RST,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_write,
  input  logic [TABLE_ID_W-1:0]           req_table,
  input  logic [CP_COL_W-1:0]             req_col,
  input  logic [CP_ROW_W-1:0]             req_row,
  input  logic [CP_DATA_W-1:0]            req_wdata,
`ifdef CP_ACCESS_MASK_EN
  input  logic [CP_DATA_W-1:0]            req_wmask,
`endif
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic [CP_DATA_W-1:0]            resp_rdata,
  output logic                            resp_err,
  output logic [NUM_TABLES-1:0]           tab_sel,
  output logic [CP_COL_W-1:0]             tab_col,
  output logic [CP_ROW_W-1:0]             tab_row,
  output logic [CP_DATA_W-1:0]            tab_wdata,
  output logic                            tab_wen,
  input  logic [CP_DATA_W*NUM_TABLES-1:0] tab_rdata,
  output logic                            busy
);

  // Last SETUP cycle index before rdata is sampled.
  localparam logic [CP_WAIT_W-1:0] RD_LAST = CP_WAIT_W'(RD_WAIT - 1);

  cp_state_e                 state_q,      state_d;
  logic                      write_q,      write_d;
  logic [TABLE_ID_W-1:0]     table_q,      table_d;
  logic [CP_WAIT_W-1:0]      cnt_q,        cnt_d;
  logic [NUM_TABLES-1:0]     tab_sel_q,    tab_sel_d;
  logic [CP_COL_W-1:0]       tab_col_q,    tab_col_d;
  logic [CP_ROW_W-1:0]       tab_row_q,    tab_row_d;
  logic [CP_DATA_W-1:0]      tab_wdata_q,  tab_wdata_d;
  logic                      tab_wen_q,    tab_wen_d;
  logic                      resp_valid_q, resp_valid_d;
  logic [CP_DATA_W-1:0]      resp_rdata_q, resp_rdata_d;
  logic                      resp_err_q,   resp_err_d;
`ifdef CP_ACCESS_MASK_EN
  logic [CP_DATA_W-1:0]      mask_q,       mask_d;
`endif

  logic                      req_bad;
  logic [NUM_TABLES-1:0]     req_onehot;
  logic [CP_DATA_W-1:0]      sel_rdata;
  logic [CP_WAIT_W-1:0]      cnt_inc;

  assign req_bad   = (32'(req_table) >= 32'(NUM_TABLES));
  assign cnt_inc   = (cnt_q == {CP_WAIT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

  assign tab_sel    = tab_sel_q;
  assign tab_col    = tab_col_q;
  assign tab_row    = tab_row_q;
  assign tab_wdata  = tab_wdata_q;
  assign tab_wen    = tab_wen_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // Read data is selected by the latched ID so it stays tied to the transaction.
  cp_table_rdata_mux #(
    .NUM_TABLES (NUM_TABLES),
    .TABLE_ID_W (TABLE_ID_W)
  ) u_rdata_mux (
    .table_id  (table_q),
    .tab_rdata (tab_rdata),
    .rdata     (sel_rdata)
  );

  // Decode the incoming table ID into a one-hot table select.
  always_comb begin
    req_onehot = '0;
    for (int i = 0; i < NUM_TABLES; i++) begin
      if (32'(req_table) == 32'(i)) begin
        req_onehot[i] = 1'b1;
      end
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    table_d      = table_q;
    cnt_d        = cnt_q;
    tab_sel_d    = tab_sel_q;
    tab_col_d    = tab_col_q;
    tab_row_d    = tab_row_q;
    tab_wdata_d  = tab_wdata_q;
    tab_wen_d    = 1'b0;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
`ifdef CP_ACCESS_MASK_EN
    mask_d       = mask_q;
`endif

    case (state_q)
      IDLE: begin
        tab_sel_d = '0;
        if (req_valid) begin
          write_d      = req_write;
          table_d      = req_table;
          cnt_d        = '0;
          resp_rdata_d = '0;
`ifdef CP_ACCESS_MASK_EN
          mask_d       = req_wmask;
`endif
          if (req_bad) begin
            // Bad ID: answer immediately, leave the table bus untouched.
            resp_err_d   = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else begin
            resp_err_d  = 1'b0;
            tab_sel_d   = req_onehot;
            tab_col_d   = req_col;
            tab_row_d   = req_row;
            tab_wdata_d = req_wdata;
            state_d     = SETUP;
          end
        end
      end

      SETUP: begin
`ifdef CP_ACCESS_MASK_EN
        // Reads and writes both wait RD_WAIT cycles; writes merge into old data.
        if (cnt_q == RD_LAST) begin
          resp_rdata_d = sel_rdata;
          if (write_q) begin
            tab_wdata_d = cp_merge(sel_rdata, tab_wdata_q, mask_q);
            tab_wen_d   = 1'b1;
            state_d     = WRITE;
          end else begin
            tab_sel_d    = '0;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end
        end else begin
          cnt_d = cnt_inc;
        end
`else
        // Full-width writes need only one setup cycle; reads wait RD_WAIT.
        if (write_q) begin
          tab_wen_d = 1'b1;
          state_d   = WRITE;
        end else if (cnt_q == RD_LAST) begin
          resp_rdata_d = sel_rdata;
          tab_sel_d    = '0;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end

      WRITE: begin
        tab_sel_d    = '0;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end

      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end

      default: begin
        tab_sel_d    = '0;
        resp_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction at once.
  always_ff @(posedge SYS_CLK or posedge DETECT_RST) begin
    if (DETECT_RST) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      table_q      <= '0;
      cnt_q        <= '0;
      tab_sel_q    <= '0;
      tab_col_q    <= '0;
      tab_row_q    <= '0;
      tab_wdata_q  <= '0;
      tab_wen_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
`ifdef CP_ACCESS_MASK_EN
      mask_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      table_q      <= table_d;
      cnt_q        <= cnt_d;
      tab_sel_q    <= tab_sel_d;
      tab_col_q    <= tab_col_d;
      tab_row_q    <= tab_row_d;
      tab_wdata_q  <= tab_wdata_d;
      tab_wen_q    <= tab_wen_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
`ifdef CP_ACCESS_MASK_EN
      mask_q       <= mask_d;
`endif
    end
  end

endmodule : cp_table_access_master
`default_nettype wire

// File: tb/tb_cp_table_access_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cp_table_access_master
//  Brief    : Self-checking bench: emulated tables on the bus, a transaction-
//             level reference model with per-cycle expectations, directed
//             cases plus randomized traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cp_table_access_master;

  localparam int NT   = 3;
  localparam int TW   = 2;
  localparam int RDW  = 3;
`ifdef CP_ACCESS_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif
  localparam int WEN_K  = MASK_EN ? RDW + 1 : 2;
  localparam int WR_LAT = WEN_K + 1;

  logic              SYS_CLK = 1'b0;
  logic              DETECT_RST = 1'b1;
  logic              req_valid = 1'b0, req_write = 1'b0;
  logic [TW-1:0]     req_table = '0;
  logic [14:0]       req_col = '0, req_row = '0;
  logic [63:0]       req_wdata = '0, req_wmask = '0;
  logic              resp_ready = 1'b0;
  logic              req_ready, resp_valid, resp_err, tab_wen, busy;
  logic [63:0]       resp_rdata, tab_wdata;
  logic [NT-1:0]     tab_sel;
  logic [14:0]       tab_col, tab_row;
  logic [64*NT-1:0]  tab_rdata;

  cp_table_access_master #(.NUM_TABLES(NT), .TABLE_ID_W(TW), .RD_WAIT(RDW)) dut (
    .SYS_CLK(SYS_CLK), .DETECT_RST(DETECT_RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_table(req_table), .req_col(req_col), .req_row(req_row),
    .req_wdata(req_wdata),
`ifdef CP_ACCESS_MASK_EN
    .req_wmask(req_wmask),
`endif
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .tab_sel(tab_sel), .tab_col(tab_col), .tab_row(tab_row),
    .tab_wdata(tab_wdata), .tab_wen(tab_wen), .tab_rdata(tab_rdata), .busy(busy)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk_key(input int t, input logic [14:0] c, input logic [14:0] r);
    return {2'(t), c, r};
  endfunction

  // Power-on contents of every table entry.
  function automatic logic [63:0] init_val(input logic [31:0] key);
    return {key, key ^ 32'hA5A5_5A5A};
  endfunction

  // ---------------- emulated tables ----------------
  logic [63:0] env_mem [logic [31:0]];
  int          mem_gen = 0;

  function automatic logic [63:0] env_read(input logic [31:0] key);
    return env_mem.exists(key) ? env_mem[key] : init_val(key);
  endfunction

  always @(tab_col or tab_row or mem_gen) begin
    for (int i = 0; i < NT; i++) tab_rdata[64*i +: 64] = env_read(mk_key(i, tab_col, tab_row));
  end

  initial begin
    logic [31:0] wkey [$];
    logic [63:0] wdat;
    forever begin
      @(posedge SYS_CLK);
      if (!DETECT_RST && tab_wen) begin
        wkey.delete();
        for (int i = 0; i < NT; i++) if (tab_sel[i]) wkey.push_back(mk_key(i, tab_col, tab_row));
        wdat = tab_wdata;
        #1;
        foreach (wkey[j]) env_mem[wkey[j]] = wdat;
        mem_gen++;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [63:0] ref_mem [logic [31:0]];
  bit          m_busy = 0, m_write = 0, m_err = 0;
  int          m_acc = 0, m_tab = 0, m_rs = 1;
  logic [14:0] m_col = '0, m_row = '0;
  logic [63:0] m_wdata = '0, m_new = '0, m_rdata = '0;

  function automatic logic [63:0] ref_read(input logic [31:0] key);
    return ref_mem.exists(key) ? ref_mem[key] : init_val(key);
  endfunction

  initial begin
    int k;
    logic [63:0] old, msk;
    forever begin
      @(posedge SYS_CLK);
      cyc++;
      if (DETECT_RST) begin
        m_busy = 0;
      end else if (m_busy) begin
        k = cyc - 1 - m_acc;
        if (m_write && !m_err && k == WEN_K) ref_mem[mk_key(m_tab, m_col, m_row)] = m_new;
        if (k >= m_rs && resp_ready) m_busy = 0;
      end else if (req_valid) begin
        m_busy  = 1;
        m_acc   = cyc - 1;
        m_write = req_write;
        m_tab   = int'(req_table);
        m_col   = req_col;
        m_row   = req_row;
        m_wdata = req_wdata;
        m_err   = (m_tab >= NT);
        msk     = MASK_EN ? req_wmask : '1;
        old     = m_err ? 64'd0 : ref_read(mk_key(m_tab, m_col, m_row));
        m_new   = (old & ~msk) | (m_wdata & msk);
        if (m_err)        begin m_rs = 1;       m_rdata = '0; end
        else if (m_write) begin m_rs = WR_LAT;  m_rdata = MASK_EN ? old : 64'd0; end
        else              begin m_rs = RDW + 1; m_rdata = old; end
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  initial begin
    int k;
    logic [NT-1:0] esel;
    bit in_wen;
    forever begin
      @(negedge SYS_CLK);
      if (DETECT_RST) begin
        chk("rst_tab_sel",    64'(tab_sel),    64'd0);
        chk("rst_tab_wen",    64'(tab_wen),    64'd0);
        chk("rst_tab_col",    64'(tab_col),    64'd0);
        chk("rst_tab_row",    64'(tab_row),    64'd0);
        chk("rst_tab_wdata",  tab_wdata,       64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_rdata", resp_rdata,      64'd0);
        chk("rst_resp_err",   64'(resp_err),   64'd0);
        chk("rst_req_ready",  64'(req_ready),  64'd1);
      end else if (!m_busy) begin
        chk("idle_req_ready",  64'(req_ready),  64'd1);
        chk("idle_busy",       64'(busy),       64'd0);
        chk("idle_tab_sel",    64'(tab_sel),    64'd0);
        chk("idle_tab_wen",    64'(tab_wen),    64'd0);
        chk("idle_resp_valid", 64'(resp_valid), 64'd0);
      end else begin
        k = cyc - m_acc;
        chk("busy_req_ready", 64'(req_ready), 64'd0);
        chk("busy_busy",      64'(busy),      64'd1);
        if (k < m_rs) begin
          esel = '0;
          esel[m_tab] = 1'b1;
          in_wen = m_write && (k == WEN_K);
          chk("xfer_resp_valid", 64'(resp_valid), 64'd0);
          chk("xfer_tab_sel",    64'(tab_sel),    64'(esel));
          chk("xfer_tab_col",    64'(tab_col),    64'(m_col));
          chk("xfer_tab_row",    64'(tab_row),    64'(m_row));
          chk("xfer_tab_wen",    64'(tab_wen),    64'(in_wen));
          chk("xfer_tab_wdata",  tab_wdata,       in_wen ? m_new : m_wdata);
        end else begin
          chk("resp_valid",   64'(resp_valid), 64'd1);
          chk("resp_rdata",   resp_rdata,      m_rdata);
          chk("resp_err",     64'(resp_err),   64'(m_err));
          chk("resp_tab_sel", 64'(tab_sel),    64'd0);
          chk("resp_tab_wen", 64'(tab_wen),    64'd0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [63:0]   t_rdata, t_wen_data;
  logic [NT-1:0] t_wen_sel;
  bit            t_err, t_sel_seen, t_wen_seen;
  int            t_lat, t_wen_k, t_waitc;

  // Random requests while busy; must be ignored by the DUT.
  task automatic noise_step(input bit allow);
    if (allow && ($urandom % 2 == 1)) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_table = TW'($urandom % NT);
      req_col   = 15'($urandom % 3);
      req_row   = 15'($urandom % 3);
      req_wdata = {$urandom, $urandom};
      req_wmask = '1;
    end else begin
      req_valid = 1'b0;
    end
  endtask

  // Called at a negedge; returns at the negedge after the response handshake.
  task automatic do_txn(input bit w, input int tab, input int col, input int row,
                        input logic [63:0] wd, input logic [63:0] wm,
                        input int rdly, input bit noise);
    int k;
    bit got;
    t_waitc = 0;
    while (!req_ready && t_waitc < 50) begin @(negedge SYS_CLK); t_waitc++; end
    if (!req_ready) chk("accept_timeout", 64'd0, 64'd1);
    req_valid = 1'b1; req_write = w; req_table = TW'(tab);
    req_col = 15'(col); req_row = 15'(row); req_wdata = wd; req_wmask = wm;
    resp_ready = (rdly == 0);
    @(posedge SYS_CLK);
    @(negedge SYS_CLK);
    req_valid = 1'b0;
    k = 1; got = 0;
    t_sel_seen = 0; t_wen_seen = 0; t_wen_k = 0; t_wen_data = '0; t_wen_sel = '0;
    while (k < 60 && !got) begin
      if (|tab_sel) t_sel_seen = 1;
      if (tab_wen && !t_wen_seen) begin
        t_wen_seen = 1; t_wen_k = k; t_wen_data = tab_wdata; t_wen_sel = tab_sel;
      end
      if (resp_valid) begin
        got = 1; t_lat = k; t_rdata = resp_rdata; t_err = resp_err;
      end else begin
        noise_step(noise);
        @(negedge SYS_CLK);
        k++;
      end
    end
    if (!got) chk("resp_timeout", 64'd0, 64'd1);
    for (int d = 0; d < rdly; d++) begin
      noise_step(noise && (d < rdly - 1));
      if (d == rdly - 1) resp_ready = 1'b1;
      @(negedge SYS_CLK);
    end
    req_valid = 1'b0;
    if (rdly == 0) @(negedge SYS_CLK);
  endtask

  initial begin
    logic [31:0] key;
    logic [63:0] rmask;
    repeat (3) @(negedge SYS_CLK);
    #2 DETECT_RST = 1'b0;
    @(negedge SYS_CLK);
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);
    chk("post_rst_busy",      64'(busy),      64'd0);

    // Write then read back table 0, col 0, row 2.
    do_txn(1, 0, 0, 2, 64'h00AB, '1, 0, 0);
    chk("wr_wen_cycle", 64'(t_wen_k),    64'(WEN_K));
    chk("wr_wen_sel",   64'(t_wen_sel),  64'b001);
    chk("wr_wen_data",  t_wen_data,      64'h00AB);
    chk("wr_latency",   64'(t_lat),      64'(WR_LAT));
    do_txn(0, 0, 0, 2, 64'h0, '0, 0, 0);
    chk("rd_data",    t_rdata,        64'h00AB);
    chk("rd_latency", 64'(t_lat),     64'd4);
    chk("rd_no_wen",  64'(t_wen_seen), 64'd0);

    // Out-of-range table ID.
    do_txn(0, 3, 1, 1, 64'h0, '0, 1, 0);
    chk("err_flag",    64'(t_err),      64'd1);
    chk("err_rdata",   t_rdata,         64'd0);
    chk("err_latency", 64'(t_lat),      64'd1);
    chk("err_no_sel",  64'(t_sel_seen), 64'd0);

    // Response held off for 5 cycles with requests arriving meanwhile.
    do_txn(0, 2, 1, 0, 64'h0, '0, 5, 1);
    chk("hold_rdata", t_rdata, init_val(mk_key(2, 15'd1, 15'd0)));

    // Reset during the setup cycle of a write.
    do_txn(0, 1, 2, 2, 64'h0, '0, 0, 0);
    req_valid = 1'b1; req_write = 1'b1; req_table = 2'd1;
    req_col = 15'd2; req_row = 15'd2; req_wdata = 64'hDEAD_BEEF; req_wmask = '1;
    @(posedge SYS_CLK);
    @(negedge SYS_CLK);
    req_valid = 1'b0;
    #2 DETECT_RST = 1'b1;
    t_wen_seen = 0;
    repeat (2) begin @(negedge SYS_CLK); if (tab_wen) t_wen_seen = 1; end
    #2 DETECT_RST = 1'b0;
    @(negedge SYS_CLK);
    chk("rst_abort_wen", 64'(t_wen_seen), 64'd0);
    do_txn(0, 1, 2, 2, 64'h0, '0, 0, 0);
    chk("rst_abort_nowrite", t_rdata, init_val(mk_key(1, 15'd2, 15'd2)));

`ifdef CP_ACCESS_MASK_EN
    // Read-modify-write merge.
    do_txn(1, 1, 1, 1, 64'h0000_0000_0000_FF00, '1, 0, 0);
    do_txn(1, 1, 1, 1, 64'h00FF, 64'h000F, 0, 0);
    chk("rmw_wdata", t_wen_data, 64'h0000_0000_0000_FF0F);
    chk("rmw_old",   t_rdata,    64'h0000_0000_0000_FF00);
    chk("rmw_lat",   64'(t_lat), 64'(RDW + 2));
    do_txn(1, 1, 1, 1, 64'h1234, 64'h0, 0, 0);
    chk("rmw_zero_mask_wen",  64'(t_wen_seen), 64'd1);
    chk("rmw_zero_mask_data", t_wen_data,      64'h0000_0000_0000_FF0F);
`endif

    // Back-to-back reads with resp_ready held high.
    for (int i = 0; i < 3; i++) begin
      do_txn(0, i, 0, 2, 64'h0, '0, 0, 0);
      chk("b2b_latency", 64'(t_lat), 64'd4);
      if (i > 0) chk("b2b_accept_gap", 64'(t_waitc), 64'd0);
    end

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      case ($urandom % 3)
        0:       rmask = '0;
        1:       rmask = '1;
        default: rmask = {$urandom, $urandom};
      endcase
      do_txn(1'($urandom % 2), int'($urandom % 4), int'($urandom % 3), int'($urandom % 3),
             {$urandom, $urandom}, rmask, int'($urandom % 4), 1'($urandom % 2));
    end

    repeat (3) @(negedge SYS_CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cp_table_access_master
`default_nettype wire

// File: doc/cp_table_access_master.md
Name: cp_table_access_master

Overview:
Initiator side of the control-plane table bus. It accepts single read/write requests over a valid/ready command channel and decodes the table ID into a one-hot table select. It drives col/row/wdata/wen to the addressed parameter table (core ptab, cache tables, etc.), samples the table's combinational rdata, and returns a response over a valid/ready channel. It sits between the control-plane command front end (JTAG/UART decoder) and all per-subsystem tables.

Parameters:
NUM_TABLES, 4, number of attached tables; width of tab_sel.
TABLE_ID_W, 2, width of req_table.
RD_WAIT, 1, cycles the address is held before rdata is sampled; legal range 1..15.

Ports:
SYS_CLK  in  1  clock
DETECT_RST  in  1  reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when high with req_valid
req_write  in  1  1=write, 0=read
req_table  in  TABLE_ID_W  target table ID
req_col  in  15  column
req_row  in  15  row
req_wdata  in  64  write data
req_wmask  in  64  bit write mask (present only with CP_ACCESS_MASK_EN)
resp_valid  out  1  response valid
resp_ready  in  1  response consumed
resp_rdata  out  64  read data or old value
resp_err  out  1  table ID out of range
tab_sel  out  NUM_TABLES  one-hot is_this_table
tab_col  out  15  table column
tab_row  out  15  table row
tab_wdata  out  64  table write data
tab_wen  out  1  table write enable
tab_rdata  in  64*NUM_TABLES  concatenated table rdata; table i at [64*i+63:64*i]
busy  out  1  state != IDLE

Behaviour:
- Reset: DETECT_RST is asynchronous, active-high; clock is SYS_CLK. On reset, state=IDLE and all registered outputs are 0 (tab_sel, tab_wen, tab_col, tab_row, tab_wdata, resp_*). req_ready=1 after reset.
- All outputs are registered except req_ready (=state==IDLE) and busy.
- States: IDLE, SETUP, WRITE, RESP.
- IDLE:
  - req_ready=1; tab_sel=0; tab_wen=0.
  - Accept on req_valid&req_ready and latch all req_* fields.
  - If req_table>=NUM_TABLES: go to RESP with resp_err=1 and resp_rdata=0. No table activity.
  - Otherwise go to SETUP with wait counter=0.
- SETUP:
  - tab_sel=one-hot(req_table); tab_col/tab_row/tab_wdata driven from latched values; tab_wen=0.
  - Read: stay until counter==RD_WAIT-1, then capture the tab_rdata slice into resp_rdata and go to RESP.
  - Write (no mask): one cycle in SETUP, then go to WRITE.
- WRITE: tab_wen=1 for exactly one cycle with address and data unchanged, then go to RESP. resp_rdata=0.
- RESP:
  - tab_sel=0, tab_wen=0, resp_valid=1.
  - Hold resp_valid/resp_rdata/resp_err stable until resp_ready; on that cycle go to IDLE.
  - No new request is accepted in the same cycle.
- Latency (accept edge = cycle 0):
  - Read: resp_valid first high at cycle RD_WAIT+1.
  - Write: tab_wen high in cycle 2, resp_valid at cycle 3.
  - Error: resp_valid at cycle 1.
- Address, select and wdata are stable from the first SETUP cycle through the last WRITE cycle.
- Only one transaction is outstanding at a time; req_valid while busy is ignored, with no side effects.
- The wait counter is 4 bits and saturates.
- Reset mid-transaction aborts immediately: tab_wen drops asynchronously, no response is produced, and no partial write is retried.
- resp_ready held high while idle has no effect.

Optional Feature:
CP_ACCESS_MASK_EN:
- With it defined, req_wmask exists. A write becomes read-modify-write:
  - SETUP runs RD_WAIT cycles, then captures old=selected tab_rdata.
  - tab_wdata is updated to (old & ~mask) | (req_wdata & mask), then WRITE, then RESP.
  - resp_rdata returns old; resp_valid arrives at cycle RD_WAIT+2.
  - mask=0 still performs the write, rewriting the old value.
- Without it, there is no mask port and writes are full 64-bit with resp_rdata=0.

Decomposition:
- Shared package cp_pkg:
  - state enum (IDLE, SETUP, WRITE, RESP)
  - CP_COL_W=15, CP_ROW_W=15, CP_DATA_W=64
  - table ID constants (TAB_CORE=0, TAB_CACHE=1, ...)
- One natural sub-module: cp_table_rdata_mux, which selects the 64-bit slice by latched table ID.

Test Plan:
- Write table 0, col 0, row 2, wdata=0x00AB, then read back. Required: tab_wen high one cycle with tab_sel=4'b0001, tab_col=0, tab_row=2; the read returns resp_rdata=0x00AB at cycle RD_WAIT+1.
- Read with req_table=3 while only NUM_TABLES=3 is configured. Required: resp_err=1, resp_rdata=0, tab_sel never asserted.
- Hold resp_ready=0 for 5 cycles after resp_valid. Required: resp_valid and data stay stable, req_ready=0 throughout, and a second req_valid is ignored.
- Assert DETECT_RST during the SETUP of a write. Required: tab_wen never asserts, state returns to IDLE, and all outputs read 0.
- With CP_ACCESS_MASK_EN: old=0x0000_0000_0000_FF00, wdata=0x00FF, mask=0x000F. Required: the table receives 0x...FF0F and resp_rdata=0xFF00.
- Back-to-back reads with resp_ready=1 and RD_WAIT=3. Required: each response arrives at cycle 4 after accept, and the next accept occurs the cycle after the response.
